// File: rtl/kyo_backward_addr_gen_if.sv
// kyo_backward_addr_gen_if: scan/position inputs and sprite-address outputs of the address generator
interface kyo_backward_addr_gen_if;
  logic        vsync;
  logic        blank;
  logic [9:0]  drawX;
  logic [9:0]  drawY;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        walk_back;
  logic [15:0] rom_address;
  logic        in_sprite;
  logic        blank_out;
  logic [2:0]  frame_idx;
  logic        playing;
  modport master (
    output vsync, blank, drawX, drawY, pos_x, pos_y, walk_back,
    input  rom_address, in_sprite, blank_out, frame_idx, playing
  );
  modport slave (
    input  vsync, blank, drawX, drawY, pos_x, pos_y, walk_back,
    output rom_address, in_sprite, blank_out, frame_idx, playing
  );
endinterface

// File: rtl/kyo_backward_addr_gen.sv
// kyo_backward_addr_gen: sprite ROM address, box test and vsync-paced walk-backward frame sequencer
module kyo_backward_addr_gen #(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 112,
  parameter int N_FRAMES   = 6,
  parameter int FRAME_HOLD = 5
) (
  input logic                   vga_clk,
  input logic                   reset_n,
  kyo_backward_addr_gen_if.slave bus
);
  localparam int HW = FRAME_HOLD > 1 ? $clog2(FRAME_HOLD) : 1;
  typedef enum logic {IDLE, PLAY} state_t;
  state_t      state_q, state_d;
  logic        vsync_q, armed_q, armed_d, tick;
  logic [9:0]  lat_x_q, lat_x_d, lat_y_q, lat_y_d;
  logic [2:0]  frame_q, frame_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0] addr_q, addr_d;
  logic        in_q, in_d, blank_q;
  logic [10:0] x_end, y_end;
  logic [9:0]  col, row;
  always_comb begin
    // armed blocks a tick when vsync is already low as reset releases
    armed_d = armed_q | bus.vsync;
    tick    = armed_q & vsync_q & ~bus.vsync;
    lat_x_d = tick ? bus.pos_x : lat_x_q;
    lat_y_d = tick ? bus.pos_y : lat_y_q;
    state_d = state_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    if (tick) begin
      if (state_q == IDLE) begin
        state_d = bus.walk_back ? PLAY : IDLE;
      end else if (hold_q == HW'(FRAME_HOLD - 1)) begin
        hold_d  = '0;
        frame_d = (frame_q == 3'(N_FRAMES - 1)) ? 3'd0 : frame_q + 3'd1;
        if (frame_q == 3'(N_FRAMES - 1) && !bus.walk_back) state_d = IDLE;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
    x_end  = {1'b0, lat_x_q} + 11'(SPR_W);
    y_end  = {1'b0, lat_y_q} + 11'(SPR_H);
    in_d   = bus.drawX >= lat_x_q && {1'b0, bus.drawX} < x_end &&
             bus.drawY >= lat_y_q && {1'b0, bus.drawY} < y_end;
    col    = bus.drawX - lat_x_q;
    row    = bus.drawY - lat_y_q;
    addr_d = in_d ? 16'(frame_q) * 16'(SPR_W * SPR_H) + 16'(row) * 16'(SPR_W) + 16'(col) : 16'd0;
  end
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      vsync_q <= 1'b1;
      armed_q <= 1'b0;
      lat_x_q <= '0;
      lat_y_q <= '0;
      frame_q <= '0;
      hold_q  <= '0;
      addr_q  <= '0;
      in_q    <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= bus.vsync;
      armed_q <= armed_d;
      lat_x_q <= lat_x_d;
      lat_y_q <= lat_y_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      in_q    <= in_d;
      blank_q <= bus.blank;
    end
  end
  assign bus.rom_address = addr_q;
  assign bus.in_sprite   = in_q;
  assign bus.blank_out   = blank_q;
  assign bus.frame_idx   = frame_q;
  assign bus.playing     = (state_q == PLAY);
endmodule

// File: tb/tb_kyo_backward_addr_gen.sv
// tb_kyo_backward_addr_gen: randomized checks of address map, latching and animation against a tick-count model
module tb_kyo_backward_addr_gen;
  localparam int W = 64, H = 112, NF = 6, FH = 5;
  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 vga_clk = ~vga_clk;
  kyo_backward_addr_gen_if bus();
  kyo_backward_addr_gen dut (.vga_clk(vga_clk), .reset_n(reset_n), .bus(bus.slave));
  int checks = 0, errors = 0;
  int lx_m = 0, ly_m = 0, k_m = 0;
  bit play_m = 0;
  function automatic int frame_m();
    return play_m ? (k_m / FH) % NF : 0;
  endfunction
  function automatic bit exp_in(input int x, input int y);
    return x >= lx_m && x < lx_m + W && y >= ly_m && y < ly_m + H;
  endfunction
  function automatic logic [15:0] exp_addr(input int x, input int y);
    int a;
    a = exp_in(x, y) ? frame_m() * W * H + (y - ly_m) * W + (x - lx_m) : 0;
    return 16'(a);
  endfunction
  task automatic vsync_tick();
    @(negedge vga_clk);
    bus.vsync = 1'b0;
    lx_m = int'(bus.pos_x);
    ly_m = int'(bus.pos_y);
    if (!play_m) begin
      if (bus.walk_back) begin play_m = 1; k_m = 0; end
    end else begin
      k_m++;
      if (k_m % (FH * NF) == 0 && !bus.walk_back) begin play_m = 0; k_m = 0; end
    end
    @(negedge vga_clk);
    bus.vsync = 1'b1;
    @(negedge vga_clk);
  endtask
  task automatic pixel(input int x, input int y, input bit b, output logic i, output logic [15:0] a, output logic bo);
    @(negedge vga_clk);
    bus.drawX = 10'(x);
    bus.drawY = 10'(y);
    bus.blank = b;
    @(negedge vga_clk);
    i  = bus.in_sprite;
    a  = bus.rom_address;
    bo = bus.blank_out;
  endtask
  task automatic test_reset();
    bus.vsync = 1'b1; bus.blank = 1'b0; bus.drawX = '0; bus.drawY = '0;
    bus.pos_x = '0; bus.pos_y = '0; bus.walk_back = 1'b0;
    repeat (3) @(negedge vga_clk);
    checks++;
    if ({bus.rom_address, bus.in_sprite, bus.blank_out, bus.frame_idx, bus.playing} !== 21'd0) begin
      errors++;
      $display("FAIL reset_values: got addr=%0d in=%0b blank=%0b frame=%0d playing=%0b, want all 0",
               bus.rom_address, bus.in_sprite, bus.blank_out, bus.frame_idx, bus.playing);
    end
    reset_n = 1'b1;
    bus.walk_back = 1'b1;
    repeat (5) @(negedge vga_clk);
    checks++;
    if (bus.playing !== 1'b0 || bus.frame_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_no_tick: got playing=%0b frame=%0d, want 0 0", bus.playing, bus.frame_idx);
    end
    bus.walk_back = 1'b0;
  endtask
  task automatic test_address_map();
    int tx[3] = '{100, 163, 164};
    int ty[3] = '{50, 161, 161};
    logic [15:0] ta[3] = '{16'd0, 16'd7167, 16'd0};
    bit ti[3] = '{1'b1, 1'b1, 1'b0};
    logic i, bo;
    logic [15:0] a;
    bus.pos_x = 10'd100; bus.pos_y = 10'd50;
    vsync_tick();
    for (int n = 0; n < 3; n++) begin
      pixel(tx[n], ty[n], 1'b1, i, a, bo);
      checks++;
      if (i !== ti[n] || a !== ta[n] || bo !== 1'b1) begin
        errors++;
        $display("FAIL addr_map_fixed (%0d,%0d): got in=%0b addr=%0d blank=%0b, want in=%0b addr=%0d blank=1",
                 tx[n], ty[n], i, a, bo, ti[n], ta[n]);
      end
    end
    for (int n = 0; n < 6; n++) begin
      bus.pos_x = 10'($urandom_range(0, 1023)); bus.pos_y = 10'($urandom_range(0, 1023));
      vsync_tick();
      for (int m = 0; m < 8; m++) begin
        int x, y;
        bit b;
        x = lx_m + int'($urandom_range(0, W + 10)) - 5;
        y = ly_m + int'($urandom_range(0, H + 10)) - 5;
        x = x < 0 ? 0 : (x > 1023 ? 1023 : x);
        y = y < 0 ? 0 : (y > 1023 ? 1023 : y);
        b = 1'($urandom_range(0, 1));
        pixel(x, y, b, i, a, bo);
        checks++;
        if ({i, a, bo} !== {exp_in(x, y), exp_addr(x, y), b}) begin
          errors++;
          $display("FAIL addr_map_rand (%0d,%0d) lat=(%0d,%0d): got in=%0b addr=%0d blank=%0b, want in=%0b addr=%0d blank=%0b",
                   x, y, lx_m, ly_m, i, a, bo, exp_in(x, y), exp_addr(x, y), b);
        end
      end
    end
  endtask
  task automatic test_latching();
    int tx[5] = '{100, 300, 300, 1023, 1023};
    int ty[5] = '{50, 50, 50, 900, 1011};
    logic [15:0] ta[5] = '{16'd0, 16'd0, 16'd0, 16'd23, 16'd7127};
    bit ti[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic i, bo;
    logic [15:0] a;
    bus.pos_x = 10'd100; bus.pos_y = 10'd50;
    vsync_tick();
    bus.pos_x = 10'd300;
    for (int n = 0; n < 5; n++) begin
      if (n == 2) vsync_tick();
      if (n == 3) begin bus.pos_x = 10'd1000; bus.pos_y = 10'd900; vsync_tick(); end
      pixel(tx[n], ty[n], 1'b0, i, a, bo);
      checks++;
      if (i !== ti[n] || a !== ta[n] || bo !== 1'b0) begin
        errors++;
        $display("FAIL latching step %0d (%0d,%0d): got in=%0b addr=%0d blank=%0b, want in=%0b addr=%0d blank=0",
                 n, tx[n], ty[n], i, a, bo, ti[n], ta[n]);
      end
    end
  endtask
  task automatic test_cadence();
    logic i, bo;
    logic [15:0] a;
    bus.pos_x = 10'($urandom_range(0, 900)); bus.pos_y = 10'($urandom_range(0, 800));
    bus.walk_back = 1'b1;
    for (int t = 0; t < 36; t++) begin
      int x, y;
      vsync_tick();
      checks++;
      if (bus.frame_idx !== 3'(frame_m()) || bus.playing !== play_m) begin
        errors++;
        $display("FAIL cadence tick %0d: got frame=%0d playing=%0b, want frame=%0d playing=%0b",
                 t, bus.frame_idx, bus.playing, frame_m(), play_m);
      end
      pixel(lx_m + 5, ly_m + 1, 1'b1, i, a, bo);
      checks++;
      if (i !== 1'b1 || a !== 16'(frame_m() * W * H + W + 5)) begin
        errors++;
        $display("FAIL frame_offset frame %0d: got in=%0b addr=%0d, want in=1 addr=%0d",
                 frame_m(), i, a, frame_m() * W * H + W + 5);
      end
      x = lx_m + int'($urandom_range(0, W - 1));
      y = ly_m + int'($urandom_range(0, H - 1));
      pixel(x, y, 1'b1, i, a, bo);
      checks++;
      if (i !== exp_in(x, y) || a !== exp_addr(x, y)) begin
        errors++;
        $display("FAIL cadence_pixel (%0d,%0d): got in=%0b addr=%0d, want in=%0b addr=%0d",
                 x, y, i, a, exp_in(x, y), exp_addr(x, y));
      end
    end
  endtask
  task automatic test_finish();
    int guard = 0;
    bus.walk_back = 1'b1;
    while (frame_m() != 2 && guard < 40) begin vsync_tick(); guard++; end
    bus.walk_back = 1'b0;
    guard = 0;
    while (play_m && guard < 40) begin
      vsync_tick();
      guard++;
      checks++;
      if (bus.frame_idx !== 3'(frame_m()) || bus.playing !== play_m) begin
        errors++;
        $display("FAIL finish tick %0d: got frame=%0d playing=%0b, want frame=%0d playing=%0b",
                 guard, bus.frame_idx, bus.playing, frame_m(), play_m);
      end
    end
    vsync_tick();
    checks++;
    if (bus.playing !== 1'b0 || bus.frame_idx !== 3'd0) begin
      errors++;
      $display("FAIL finish_idle: got playing=%0b frame=%0d, want 0 0", bus.playing, bus.frame_idx);
    end
  endtask
  task automatic test_walk_pulse();
    @(negedge vga_clk);
    bus.walk_back = 1'b1;
    repeat (3) @(negedge vga_clk);
    bus.walk_back = 1'b0;
    vsync_tick();
    checks++;
    if (bus.playing !== play_m || bus.frame_idx !== 3'(frame_m())) begin
      errors++;
      $display("FAIL walk_pulse_ignored: got playing=%0b frame=%0d, want playing=%0b frame=%0d",
               bus.playing, bus.frame_idx, play_m, frame_m());
    end
  endtask
  task automatic test_reset_mid();
    int guard = 0;
    logic i, bo;
    logic [15:0] a;
    bus.walk_back = 1'b1;
    while (frame_m() != 3 && guard < 40) begin vsync_tick(); guard++; end
    pixel(lx_m, ly_m, 1'b1, i, a, bo);
    @(negedge vga_clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.rom_address, bus.in_sprite, bus.blank_out, bus.frame_idx, bus.playing} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got addr=%0d in=%0b blank=%0b frame=%0d playing=%0b, want all 0",
               bus.rom_address, bus.in_sprite, bus.blank_out, bus.frame_idx, bus.playing);
    end
    play_m = 0; k_m = 0; lx_m = 0; ly_m = 0;
    bus.vsync = 1'b0;
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;
    repeat (6) @(negedge vga_clk);
    checks++;
    if (bus.playing !== 1'b0 || bus.frame_idx !== 3'd0) begin
      errors++;
      $display("FAIL vsync_low_release: got playing=%0b frame=%0d, want 0 0", bus.playing, bus.frame_idx);
    end
    bus.vsync = 1'b1;
    repeat (2) @(negedge vga_clk);
    vsync_tick();
    checks++;
    if (bus.playing !== 1'b1 || bus.frame_idx !== 3'd0) begin
      errors++;
      $display("FAIL restart_after_reset: got playing=%0b frame=%0d, want 1 0", bus.playing, bus.frame_idx);
    end
  endtask
  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_address_map();
    test_latching();
    test_cadence();
    test_finish();
    test_walk_pulse();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
